uart_tx_arbiter: RTL and testbench

- Shares one memory-backed serial transmit datapath between NREQ requesters.
- Each requester asks for an inclusive byte range [start, end] of the message memory. The block grants one requester at a time, round-robin.
- For the granted range it reads each byte from memory and serialises it: start bit 0, 8 data bits LSB first, stop bit 1, one bit per clk.
- It sits between the client logic and the message ROM; its serial output feeds the receiver side of the link.

---
 rtl/uart_ctl_pkg.sv | 14 +
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ctl_pkg.sv
// Shared definitions for the arbitrated serial transmitter: FSM encoding and frame constants.
package uart_ctl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DATA = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam int   FRAME_BITS = 8;
    localparam logic LINE_IDLE  = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client request/grant bus, message-memory read port and serial line of the shared transmitter.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] start_addr;
    logic [NREQ*AW-1:0] end_addr;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_data;
    logic               tout;
    logic               busy;

    modport master (
        output req, start_addr, end_addr, mem_data,
        input  grant, done, mem_addr, tout, busy
    );

    modport slave (
        input  req, start_addr, end_addr, mem_data,
        output grant, done, mem_addr, tout, busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping around.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [PW-1:0]   pick_idx,
    output logic            valid
);

    logic [PW-1:0] idx;

    // Walk from farthest to nearest so the requester closest to ptr overrides the rest.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        valid    = 1'b0;
        idx      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
                pick_idx  = idx;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin shared transmitter: reads a byte range from the message memory and
// serialises each byte as start, 8 data bits LSB first, stop, one bit per clock.
module uart_tx_arbiter
    import uart_ctl_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 4,
    parameter int DW   = 8
) (
    input logic             clk,
    input logic             rst,
    uart_tx_arbiter_if.slave bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(FRAME_BITS);

    state_t          state, state_nxt;
    logic [DW-1:0]   shift, shift_nxt;
    logic [BW-1:0]   bitcnt, bitcnt_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [AW-1:0]   end_reg, end_nxt;
    logic [AW-1:0]   addr, addr_nxt;
    logic            tout, tout_nxt;
    logic [NREQ-1:0] grant, grant_nxt;
    logic [NREQ-1:0] done, done_nxt;

    logic [NREQ-1:0] arb_pick;
    logic [PW-1:0]   arb_idx;
    logic            arb_valid;
    logic [AW-1:0]   start_arr [NREQ];
    logic [AW-1:0]   end_arr   [NREQ];

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req      (bus.req),
        .ptr      (ptr),
        .pick     (arb_pick),
        .pick_idx (arb_idx),
        .valid    (arb_valid)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            start_arr[i] = bus.start_addr[i*AW +: AW];
            end_arr[i]   = bus.end_addr[i*AW +: AW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bitcnt  <= '0;
            ptr     <= '0;
            end_reg <= '0;
            addr    <= '0;
            tout    <= LINE_IDLE;
            grant   <= '0;
            done    <= '0;
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bitcnt  <= bitcnt_nxt;
            ptr     <= ptr_nxt;
            end_reg <= end_nxt;
            addr    <= addr_nxt;
            tout    <= tout_nxt;
            grant   <= grant_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shift_nxt  = shift;
        bitcnt_nxt = bitcnt;
        ptr_nxt    = ptr;
        end_nxt    = end_reg;
        addr_nxt   = addr;
        tout_nxt   = tout;
        grant_nxt  = grant;
        done_nxt   = '0;
        case (state)
            IDLE: begin
                tout_nxt  = LINE_IDLE;
                grant_nxt = '0;
                if (arb_valid) begin
                    ptr_nxt = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                    // An inverted range is acknowledged immediately without sending anything.
                    if (start_arr[arb_idx] > end_arr[arb_idx]) begin
                        done_nxt = arb_pick;
                    end else begin
                        grant_nxt = arb_pick;
                        addr_nxt  = start_arr[arb_idx];
                        end_nxt   = end_arr[arb_idx];
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                shift_nxt  = bus.mem_data;
                tout_nxt   = 1'b0;
                bitcnt_nxt = '0;
                state_nxt  = DATA;
            end
            DATA: begin
                tout_nxt   = shift[bitcnt];
                bitcnt_nxt = bitcnt + 1'b1;
                if (bitcnt == BW'(FRAME_BITS - 1)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                tout_nxt = LINE_IDLE;
                if (addr == end_reg) begin
                    done_nxt  = grant;
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    addr_nxt  = addr + 1'b1;
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.grant    = grant;
    assign bus.done     = done;
    assign bus.mem_addr = addr;
    assign bus.tout     = tout;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus queues expected frames/done pulses, a UART-receiver monitor checks them.
module tb_uart_tx_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 4;
    localparam int DW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [16];
    assign bus.mem_data = mem[bus.mem_addr];

    typedef struct {
        int            id;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        bit            b2b;
    } frame_t;

    frame_t exp_frames[$];
    int     exp_done[$];
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: decodes the serial line like a receiver and pops expectations.
    initial begin : monitor
        int            nbits;
        bit            in_frame;
        logic [7:0]    sh;
        logic [AW-1:0] a0;
        logic [NREQ-1:0] g0;
        int            gap;
        int            id;
        frame_t        f;
        nbits = 0; in_frame = 0; sh = '0; a0 = '0; g0 = '0; gap = 1; id = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                in_frame = 0;
                gap = 1;
                continue;
            end
            if (bus.done != '0) begin
                if (exp_done.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: done=%b, expected none", bus.done);
                end else begin
                    id = exp_done.pop_front();
                    chk("done_onehot", 32'(bus.done), 32'(1 << id));
                    chk("done_grant_overlap", 32'(bus.done & bus.grant), 32'd0);
                    chk("busy_at_done", 32'(bus.busy), 32'd0);
                end
            end
            if (!in_frame) begin
                if (bus.tout == 1'b0) begin
                    in_frame = 1; nbits = 0; a0 = bus.mem_addr; g0 = bus.grant;
                    if (exp_frames.size() > 0 && exp_frames[0].b2b) chk("b2b_gap", 32'(gap), 32'd0);
                end else begin
                    gap++;
                end
            end else if (nbits < 8) begin
                sh[nbits] = bus.tout;
                nbits++;
            end else begin
                chk("stop_bit", 32'(bus.tout), 32'd1);
                in_frame = 0;
                gap = 0;
                if (exp_frames.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame: data=%0h, expected none", sh);
                end else begin
                    f = exp_frames.pop_front();
                    chk("frame_data", 32'(sh), 32'(f.data));
                    chk("frame_addr", 32'(a0), 32'(f.addr));
                    chk("frame_grant", 32'(g0), 32'(1 << f.id));
                end
            end
        end
    end

    task automatic set_range(input int id, input int s, input int e);
        bus.start_addr[id*AW +: AW] = AW'(s);
        bus.end_addr[id*AW +: AW]   = AW'(e);
    endtask

    task automatic expect_xfer(input int id, input int s, input int e);
        frame_t f;
        for (int a = s; a <= e; a++) begin
            f.id = id; f.addr = AW'(a); f.data = mem[a]; f.b2b = (a != s);
            exp_frames.push_back(f);
        end
        exp_done.push_back(id);
    endtask

    task automatic serve(input logic [NREQ-1:0] who, input bit drop_after_grant);
        logic [NREQ-1:0] pend;
        int cyc;
        pend = who;
        cyc  = 0;
        @(negedge clk);
        bus.req = bus.req | who;
        while (pend != '0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (drop_after_grant && (bus.grant & bus.req) != '0) bus.req = bus.req & ~bus.grant;
            if ((bus.done & pend) != '0) begin
                bus.req = bus.req & ~bus.done;
                pend    = pend & ~bus.done;
            end
        end
        if (pend != '0) begin
            checks++; errors++;
            $display("FAIL serve_timeout: pending=%b, expected 00", pend);
            bus.req = '0;
        end
    endtask

    task automatic contend(input int first, input int s0, input int e0, input int s1, input int e1);
        set_range(0, s0, e0);
        set_range(1, s1, e1);
        if (first == 0) begin
            expect_xfer(0, s0, e0); expect_xfer(1, s1, e1);
        end else begin
            expect_xfer(1, s1, e1); expect_xfer(0, s0, e0);
        end
        serve(2'b11, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int cyc;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2]  = 8'h81; mem[3]  = 8'hE7;
        mem[4] = 8'h1F; mem[5] = 8'h3F; mem[6]  = 8'h7F; mem[7]  = 8'h96;
        mem[8] = 8'hC6; mem[9] = 8'h5A; mem[10] = 8'h0F; mem[11] = 8'hF0;
        bus.req = '0; bus.start_addr = '0; bus.end_addr = '0;

        repeat (3) @(negedge clk);
        chk("rst_tout", 32'(bus.tout), 32'd1);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        contend(0, 2, 2, 8, 8);
        contend(0, 3, 3, 7, 7);

        // Single byte 0x1F on requester 0 leaves the pointer at requester 1.
        set_range(0, 4, 4); expect_xfer(0, 4, 4); serve(2'b01, 1'b0);
        repeat (2) @(negedge clk);
        contend(1, 0, 0, 9, 9);

        set_range(0, 4, 6); expect_xfer(0, 4, 6); serve(2'b01, 1'b0);
        repeat (2) @(negedge clk);

        // Inverted range: only a done pulse, and the pointer still advances to 0.
        set_range(1, 9, 3); exp_done.push_back(1); serve(2'b10, 1'b0);
        repeat (2) @(negedge clk);
        contend(0, 5, 5, 10, 10);

        // Reset while bit 3 of 0x81 (a zero) is on the line.
        set_range(0, 2, 2);
        @(negedge clk);
        bus.req[0] = 1'b1;
        cyc = 0;
        while (bus.tout !== 1'b0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_start_seen", 32'(bus.tout), 32'd0);
        repeat (4) @(negedge clk);
        chk("abort_bit3_low", 32'(bus.tout), 32'd0);
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk);
        chk("abort_tout", 32'(bus.tout), 32'd1);
        chk("abort_grant", 32'(bus.grant), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        contend(0, 6, 6, 11, 11);

        // Requester withdraws right after its grant; both bytes must still go out.
        set_range(0, 0, 1); expect_xfer(0, 0, 1); serve(2'b01, 1'b1);

        repeat (5) @(negedge clk);
        chk("frames_drained", 32'(exp_frames.size()), 32'd0);
        chk("done_drained", 32'(exp_done.size()), 32'd0);
        chk("final_idle_tout", 32'(bus.tout), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
